// File: rtl/writeback_arbiter_if.sv
// Unit writeback bus between the execution units and the writeback arbiter.
// The slave modport is the arbiter; the master modport is the unit/pipeline side.
interface writeback_arbiter_if #(
    parameter int NUM_UNITS = 4,
    parameter int ID_W      = 3,
    parameter int XLEN      = 32
);
    logic [NUM_UNITS-1:0]      unit_done;
    logic [NUM_UNITS*ID_W-1:0] unit_id;
    logic [NUM_UNITS*XLEN-1:0] unit_rd;
    logic [NUM_UNITS-1:0]      unit_ack;
    logic                      wb_valid;
    logic [ID_W-1:0]           wb_id;
    logic [XLEN-1:0]           wb_data;
    logic                      cnt_clear;
    logic [NUM_UNITS*16-1:0]   conflict_count;

    modport master (
        output unit_done, unit_id, unit_rd, cnt_clear,
        input  unit_ack, wb_valid, wb_id, wb_data, conflict_count
    );

    modport slave (
        input  unit_done, unit_id, unit_rd, cnt_clear,
        output unit_ack, wb_valid, wb_id, wb_data, conflict_count
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: unit 0 has absolute priority, units 1..N-1 share round-robin.
// Optional per-unit denied-cycle counters are enabled by WB_ARB_CONFLICT_COUNTERS_EN.
module writeback_arbiter #(
    parameter int NUM_UNITS = 4,
    parameter int ID_W      = 3,
    parameter int XLEN      = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    writeback_arbiter_if.slave bus
);
    localparam int PTR_W   = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int RR_SPAN = (NUM_UNITS > 1) ? NUM_UNITS - 1 : 1;

    logic [NUM_UNITS-1:0] w_ack;
    logic                 w_found;
    logic [PTR_W-1:0]     w_idx;
    logic                 w_grant;
    logic [ID_W-1:0]      w_gnt_id;
    logic [XLEN-1:0]      w_gnt_data;
    logic [PTR_W-1:0]     w_rr_next;
    logic [PTR_W-1:0]     r_rr_ptr;
    logic                 r_wb_valid;
    logic [ID_W-1:0]      r_wb_id;
    logic [XLEN-1:0]      r_wb_data;

    // Grant selection: unit 0 first, then a cyclic search of 1..N-1 from r_rr_ptr
    always_comb begin
        w_ack   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        if (!rst_n) begin
            w_ack = '0;
        end else if (bus.unit_done[0]) begin
            w_ack[0] = 1'b1;
        end else begin
            for (int i = 0; i < NUM_UNITS - 1; i++) begin
                w_idx = PTR_W'(((int'(r_rr_ptr) - 1 + i) % RR_SPAN) + 1);
                if (!w_found && bus.unit_done[w_idx]) begin
                    w_ack[w_idx] = 1'b1;
                    w_found      = 1'b1;
                end else begin
                    w_found = w_found;
                end
            end
        end
    end

    // AND-OR mux of the granted result; relies on w_ack being one-hot or zero
    always_comb begin
        w_gnt_id   = '0;
        w_gnt_data = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            w_gnt_id   = w_gnt_id   | ({ID_W{w_ack[k]}} & bus.unit_id[k*ID_W +: ID_W]);
            w_gnt_data = w_gnt_data | ({XLEN{w_ack[k]}} & bus.unit_rd[k*XLEN +: XLEN]);
        end
    end

    // Next pointer: one past the granted multi-cycle unit, skipping index 0 on wrap
    always_comb begin
        w_rr_next = r_rr_ptr;
        for (int k = 1; k < NUM_UNITS; k++) begin
            if (w_ack[k]) begin
                w_rr_next = (k == NUM_UNITS - 1) ? PTR_W'(1) : PTR_W'(k + 1);
            end else begin
                w_rr_next = w_rr_next;
            end
        end
    end

    assign w_grant = |w_ack;

    // Output register and round-robin pointer; id/data hold on idle cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid <= 1'b0;
            r_wb_id    <= '0;
            r_wb_data  <= '0;
            r_rr_ptr   <= PTR_W'(1);
        end else begin
            r_wb_valid <= w_grant;
            r_rr_ptr   <= w_rr_next;
            if (w_grant) begin
                r_wb_id   <= w_gnt_id;
                r_wb_data <= w_gnt_data;
            end else begin
                r_wb_id   <= r_wb_id;
                r_wb_data <= r_wb_data;
            end
        end
    end

    assign bus.unit_ack = w_ack;
    assign bus.wb_valid = r_wb_valid;
    assign bus.wb_id    = r_wb_id;
    assign bus.wb_data  = r_wb_data;

`ifdef WB_ARB_CONFLICT_COUNTERS_EN
    logic [15:0] r_cnt [NUM_UNITS];

    // Denied-cycle counters: clear beats increment, saturating at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_UNITS; k++) begin
                r_cnt[k] <= 16'h0000;
            end
        end else if (bus.cnt_clear) begin
            for (int k = 0; k < NUM_UNITS; k++) begin
                r_cnt[k] <= 16'h0000;
            end
        end else begin
            for (int k = 0; k < NUM_UNITS; k++) begin
                if (bus.unit_done[k] && !w_ack[k] && (r_cnt[k] != 16'hFFFF)) begin
                    r_cnt[k] <= r_cnt[k] + 16'd1;
                end else begin
                    r_cnt[k] <= r_cnt[k];
                end
            end
        end
    end

    // Pack counters onto the flat output bus
    always_comb begin
        bus.conflict_count = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            bus.conflict_count[k*16 +: 16] = r_cnt[k];
        end
    end
`else
    logic w_unused_cnt_clear;
    assign w_unused_cnt_clear = bus.cnt_clear;
    assign bus.conflict_count = '0;
`endif
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: priority, round-robin, hold, reset, counters.
module tb_writeback_arbiter;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    writeback_arbiter_if #(.NUM_UNITS(4), .ID_W(3), .XLEN(32)) bus ();

    writeback_arbiter #(.NUM_UNITS(4), .ID_W(3), .XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_unit(input int k, input logic done, input logic [2:0] id,
                            input logic [31:0] rd);
        bus.unit_done[k]        = done;
        bus.unit_id[k*3 +: 3]   = id;
        bus.unit_rd[k*32 +: 32] = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wb(input string tag, input logic v, input logic [2:0] id,
                          input logic [31:0] d);
        chk({tag, "_valid"}, 32'(bus.wb_valid), 32'(v));
        chk({tag, "_id"},    32'(bus.wb_id),    32'(id));
        chk({tag, "_data"},  bus.wb_data,       d);
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst_n         = 1'b0;
        bus.unit_done = 4'b0000;
        bus.unit_id   = 12'h000;
        bus.unit_rd   = 128'h0;
        bus.cnt_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", 32'(bus.unit_ack), 32'h0);
        chk_wb("rst", 1'b0, 3'd0, 32'h0);
        chk("rst_cnt", 32'(|bus.conflict_count), 32'h0);
        #2 rst_n = 1'b1;
        tick();

        // unit 0 wins over everyone, pointer unchanged
        set_unit(0, 1'b1, 3'd5, 32'hDEADBEEF);
        set_unit(1, 1'b1, 3'd1, 32'h1111_0001);
        set_unit(2, 1'b1, 3'd2, 32'h2222_0002);
        set_unit(3, 1'b1, 3'd3, 32'h3333_0003);
        #1 chk("prio_ack", 32'(bus.unit_ack), 32'h1);
        tick();
        chk_wb("prio", 1'b1, 3'd5, 32'hDEADBEEF);

        // round-robin across 1,2,3 and wrap to 1
        set_unit(0, 1'b0, 3'd0, 32'h0);
        #1 chk("rr1_ack", 32'(bus.unit_ack), 32'h2);
        tick();
        chk_wb("rr1", 1'b1, 3'd1, 32'h1111_0001);
        chk("rr2_ack", 32'(bus.unit_ack), 32'h4);
        tick();
        chk_wb("rr2", 1'b1, 3'd2, 32'h2222_0002);
        chk("rr3_ack", 32'(bus.unit_ack), 32'h8);
        tick();
        chk_wb("rr3", 1'b1, 3'd3, 32'h3333_0003);
        chk("rr4_ack", 32'(bus.unit_ack), 32'h2);
        tick();
        chk_wb("rr4", 1'b1, 3'd1, 32'h1111_0001);

        // single grant then idle: valid drops, id/data hold
        set_unit(1, 1'b0, 3'd0, 32'h0);
        set_unit(3, 1'b0, 3'd0, 32'h0);
        set_unit(2, 1'b1, 3'd6, 32'h12345678);
        #1 chk("hold_ack", 32'(bus.unit_ack), 32'h4);
        tick();
        chk_wb("hold_g", 1'b1, 3'd6, 32'h12345678);
        set_unit(2, 1'b0, 3'd0, 32'h0);
        #1 chk("idle_ack", 32'(bus.unit_ack), 32'h0);
        tick();
        chk_wb("idle1", 1'b0, 3'd6, 32'h12345678);
        tick();
        chk_wb("idle2", 1'b0, 3'd6, 32'h12345678);

        // sole requester granted on consecutive cycles, across pointer wrap
        set_unit(3, 1'b1, 3'd7, 32'hA5A5A5A5);
        #1 chk("b2b1_ack", 32'(bus.unit_ack), 32'h8);
        tick();
        chk_wb("b2b1", 1'b1, 3'd7, 32'hA5A5A5A5);
        set_unit(3, 1'b1, 3'd4, 32'h5A5A5A5A);
        #1 chk("b2b2_ack", 32'(bus.unit_ack), 32'h8);
        tick();
        chk_wb("b2b2", 1'b1, 3'd4, 32'h5A5A5A5A);

        // unit 0 starves unit 3 for five cycles
        bus.cnt_clear = 1'b1;
        set_unit(3, 1'b0, 3'd0, 32'h0);
        tick();
        bus.cnt_clear = 1'b0;
        chk("clr0_cnt", 32'(|bus.conflict_count), 32'h0);
        set_unit(0, 1'b1, 3'd2, 32'hCAFE0000);
        set_unit(3, 1'b1, 3'd3, 32'h3333_0003);
        for (int i = 0; i < 5; i++) begin
            #1 chk("starve_ack", 32'(bus.unit_ack), 32'h1);
            tick();
        end
        chk_wb("starve", 1'b1, 3'd2, 32'hCAFE0000);
`ifdef WB_ARB_CONFLICT_COUNTERS_EN
        chk("cnt3_5", 32'(bus.conflict_count[3*16 +: 16]), 32'h5);
        chk("cnt0_5", 32'(bus.conflict_count[0 +: 16]), 32'h0);
        bus.cnt_clear = 1'b1;
        tick();
        bus.cnt_clear = 1'b0;
        chk("cnt3_clr", 32'(bus.conflict_count[3*16 +: 16]), 32'h0);
        repeat (70000) @(posedge clk);
        #1;
        chk("cnt3_sat", 32'(bus.conflict_count[3*16 +: 16]), 32'hFFFF);
        chk("cnt0_sat", 32'(bus.conflict_count[0 +: 16]), 32'h0);
`else
        chk("cnt_off", 32'(|bus.conflict_count), 32'h0);
`endif

        // reset mid-operation: pointer moved to 2, reset returns it to 1
        set_unit(0, 1'b0, 3'd0, 32'h0);
        set_unit(3, 1'b0, 3'd0, 32'h0);
        set_unit(1, 1'b1, 3'd1, 32'h1111_0001);
        set_unit(2, 1'b1, 3'd2, 32'h2222_0002);
        #1 chk("mid_ack1", 32'(bus.unit_ack), 32'h2);
        tick();
        chk("mid_ack2", 32'(bus.unit_ack), 32'h4);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_ack", 32'(bus.unit_ack), 32'h0);
        chk_wb("arst", 1'b0, 3'd0, 32'h0);
        rst_n = 1'b1;
        #1 chk("post_ack", 32'(bus.unit_ack), 32'h2);
        tick();
        chk_wb("post", 1'b1, 3'd1, 32'h1111_0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Receiving end of the unit writeback interface.
- Collects done/id/rd results from NUM_UNITS execution units and grants one unit per cycle.
- Registers the granted result toward the register file and ID-retire logic.
- Unit 0 is the single-cycle ALU, which cannot hold a result and therefore has absolute priority. Units 1..NUM_UNITS-1 (multi-cycle: load/store, mul, div, CSR) share round-robin arbitration.

Parameters:
- NUM_UNITS, 4, number of writeback sources (>=1); index 0 is the non-holding single-cycle unit.
- ID_W, 3, width of instruction ID.
- XLEN, 32, result data width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
- unit_done  input  NUM_UNITS  per-unit result valid.
- unit_id  input  NUM_UNITS*ID_W  per-unit instruction ID; unit k at [k*ID_W +: ID_W].
- unit_rd  input  NUM_UNITS*XLEN  per-unit result; unit k at [k*XLEN +: XLEN].
- unit_ack  output  NUM_UNITS  one-hot grant, combinational, same cycle as done.
- wb_valid  output  1  registered result valid.
- wb_id  output  ID_W  registered granted ID.
- wb_data  output  XLEN  registered granted result.
- cnt_clear  input  1  synchronous clear of conflict counters (optional feature only).
- conflict_count  output  NUM_UNITS*16  per-unit denied-cycle counters (optional feature only).

Behaviour:
- Reset (rst_n low, asynchronous):
  - wb_valid=0, wb_id=0, wb_data=0.
  - Round-robin pointer rr_ptr=1; counters=0.
  - unit_ack forced to 0 while rst_n is low.
- Grant:
  - If unit_done[0]=1, unit_ack[0]=1 and all other acks are 0.
  - Otherwise, grant the first requesting unit in 1..NUM_UNITS-1, searching cyclically from rr_ptr.
  - unit_ack is one-hot or zero, never multi-hot.
- Holding rule: units 1..N-1 keep done/id/rd stable until acked. Their done deasserts the cycle after ack unless they have a new result. Unit 0 needs no hold, since it is always acked when done.
- Pointer: after a grant to unit k>=1, rr_ptr = k+1, wrapping from NUM_UNITS-1 to 1 (0 is skipped). No change on a unit-0 grant or an idle cycle.
- Latency: 1 cycle. On a grant in cycle t: wb_valid=1, wb_id=granted id, wb_data=granted rd in cycle t+1.
- No grant in cycle t: wb_valid=0 in t+1; wb_id/wb_data hold their last values.
- No back-pressure: the downstream always accepts, so every granted result is delivered exactly once.
- Back-to-back grants to the same unit are allowed on consecutive cycles when it is the only requester.
- NUM_UNITS=1: a registered pass-through of unit 0; rr_ptr is unused.
- Simultaneous done from unit 0 and all others: unit 0 wins, and the others stall that cycle without a pointer change.

Optional Feature:
- Macro WB_ARB_CONFLICT_COUNTERS_EN.
- Defined:
  - Per-unit 16-bit counter increments each cycle where unit_done[k]=1 and unit_ack[k]=0.
  - Counters saturate at 16'hFFFF.
  - cnt_clear=1 zeroes all counters on the next edge and takes priority over increment.
  - Counter k is driven on conflict_count[k*16 +: 16].
- Undefined: no counter logic; conflict_count tied to 0; cnt_clear ignored.

Test Plan:
- Reset mid-operation: units 1,2 done; drop rst_n asynchronously -> wb_valid=0, unit_ack=0 immediately; after release rr_ptr=1, so unit 1 is granted first.
- Unit 0 priority: unit_done=4'b1111, unit_id[0]=3'd5, unit_rd[0]=32'hDEADBEEF -> unit_ack=4'b0001; next cycle wb_valid=1, wb_id=5, wb_data=32'hDEADBEEF.
- Round-robin wrap: units 1,2,3 held done, unit 0 idle -> acks 0010, 0100, 1000, 0010 on consecutive cycles, each with wb_valid=1 one cycle later.
- Idle hold: one grant with data 32'h12345678, then no done -> wb_valid=0, wb_data stays 32'h12345678.
- Counters (macro defined): unit 0 done for 5 cycles while unit 3 held done -> conflict_count[3]=5; cnt_clear pulse -> 0; 70000 stalled cycles -> saturates at 16'hFFFF.
